arp_cache: RTL
==============

# arp_cache

Parametrised IP→MAC resolution cache for the Ethernet stack, between the ARP receive/transmit path and any IP-layer sender. Learns bindings from received ARP packets, serves lookups with a ready/done handshake, and on a miss drives ARP requests itself with retry and timeout. Entries age out on a divided tick. Supersedes the fixed single-peer latch of received PC MAC/IP.

## Interface
- ENTRIES, 8: table depth (≥2)
- TICK_DIV, 125000: clk cycles per age/timeout tick (1 ms at 125 MHz)
- AGE_MAX, 60000: ticks until an unrefreshed entry is invalidated
- RETRY_TIMEOUT, 1000: ticks waited after each request
- RETRY_MAX, 3: requests sent before a lookup fails

- clk  in  1  single clock, all logic rising-edge
- rstn  in  1  asynchronous, active-low reset
- learn_valid  in  1  one-cycle pulse; binding from ARP rx (rx done)
- learn_ip  in  32  sender IP
- learn_mac  in  48  sender MAC
- lookup_req  in  1  lookup request, accepted only when lookup_ready=1
- lookup_ip  in  32  IP to resolve, sampled on acceptance
- lookup_ready  out  1  idle, can accept a lookup
- lookup_done  out  1  one-cycle result pulse
- lookup_hit  out  1  valid with lookup_done: 1 = resolved
- lookup_mac  out  48  valid with lookup_done; 0 when hit=0
- req_en  out  1  one-cycle pulse to ARP tx: send request (op=1)
- req_ip  out  32  target IP, stable from req_en until next request
- req_busy  in  1  ARP tx busy; req_en never asserted while high
- flush  in  1  one-cycle pulse: invalidate all entries
- entry_count  out  $clog2(ENTRIES+1)  number of valid entries

## Operation
- Reset: all entries invalid, ages 0, FSM IDLE, lookup_ready=1, all other outputs 0.
- Learn (learn_valid=1): IP already present → overwrite MAC, age=0. Else first invalid slot (lowest index). Else table full → replace entry with largest age, lowest index on tie. Written at the next edge.
- flush has priority over a same-cycle learn (learn dropped); aborts an active lookup: next cycle lookup_done=1, hit=0.
- Ageing: free-running tick every TICK_DIV cycles; each valid entry's age saturating +1; entry whose age reaches AGE_MAX becomes invalid on that tick. A learn refreshing the same entry in the tick cycle wins (age=0, stays valid).
- FSM states IDLE, SEND, WAIT, DONE.
  - IDLE: ready=1. On accept, compare lookup_ip against all valid entries plus same-cycle learn_ip (bypass). Hit → DONE with that MAC. Miss → SEND, retry count=0.
  - SEND: wait for req_busy=0; pulse req_en with req_ip=lookup IP; retry count +1 → WAIT, tick timer cleared.
  - WAIT: learn_valid with learn_ip == lookup IP → DONE hit, mac=learn_mac. RETRY_TIMEOUT-th tick since entering WAIT → SEND if count<RETRY_MAX else DONE miss.
  - DONE: lookup_done=1 for one cycle → IDLE.
- Learn match in WAIT in the same cycle as timeout: match wins.
- Learns from unrelated IPs are always written, in every state.

## Timing
- Hit: lookup_req accepted at cycle N → lookup_done/hit/mac at N+1 → ready=1 at N+2.
- Miss: req_en earliest N+1 (req_busy=0). Learned reply at cycle M → lookup_done at M+1; entry readable by next lookup from M+1.
- Miss with no reply: exactly RETRY_MAX req_en pulses, lookup_done hit=0 on cycle after final timeout.
- Timeout granularity: one tick (tick phase not reset by WAIT entry).
- entry_count registered, reflects table state after each edge.

## Structure
- Package arp_pkg: IP_W=32, MAC_W=48, ARP_OP_REQ=1, ARP_OP_REPLY=0, FSM state encoding; shared with ARP tx/rx.
- Sub-module arp_cache_table: valid/ip/mac/age arrays, parallel match, free-slot and oldest-slot selection, ageing, flush. Top holds tick divider and lookup FSM.

## Test plan
- Learn 192.168.1.10 / 00:11:22:33:44:55, lookup same IP → done at N+1, hit=1, mac=00:11:22:33:44:55, no req_en.
- Lookup 192.168.1.20 on empty table, learn reply 5 ticks later → one req_en with req_ip=192.168.1.20, done hit=1 at learn+1, entry_count=1.
- Lookup unknown IP, no reply (RETRY_MAX=3, RETRY_TIMEOUT=4) → 3 req_en pulses 4 ticks apart, then done hit=0.
- Fill ENTRIES+1 distinct IPs with staggered ticks → oldest evicted, entry_count=ENTRIES, evicted IP lookup misses.
- req_busy held high 20 cycles during SEND → req_en delayed until first cycle req_busy=0; flush during WAIT → done hit=0, entry_count=0.
- Assert rstn low during WAIT → all outputs to reset values immediately, subsequent lookup misses.

Source files
------------

// File: rtl/arp_pkg.sv
// arp_pkg: definitions shared by the ARP cache and the ARP tx/rx blocks.
//   IP_W / MAC_W      : address widths
//   ARP_OP_REQ/REPLY  : ARP opcode values as used by the tx path
//   arp_state_e       : lookup FSM state encoding
package arp_pkg;

  localparam int IP_W         = 32;
  localparam int MAC_W        = 48;
  localparam int ARP_OP_REQ   = 1;
  localparam int ARP_OP_REPLY = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } arp_state_e;

endpackage

// File: rtl/arp_cache_table.sv
// arp_cache_table: IP->MAC binding store.
//   clk, rstn          : clock, asynchronous active-low reset
//   tick               : one-cycle age tick from the divider
//   flush              : invalidate everything (beats a same-cycle learn)
//   learn_valid/ip/mac : binding to write at the next edge
//   lookup_ip          : address compared in parallel against valid entries
//   lookup_hit/mac     : combinational match result
//   entry_count        : registered number of valid entries
module arp_cache_table
  import arp_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int AGE_MAX = 60000
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         tick,
  input  logic                         flush,
  input  logic                         learn_valid,
  input  logic [IP_W-1:0]              learn_ip,
  input  logic [MAC_W-1:0]             learn_mac,
  input  logic [IP_W-1:0]              lookup_ip,
  output logic                         lookup_hit,
  output logic [MAC_W-1:0]             lookup_mac,
  output logic [$clog2(ENTRIES+1)-1:0] entry_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int AGE_W = $clog2(AGE_MAX + 1);
  localparam int CNT_W = $clog2(ENTRIES + 1);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [AGE_W-1:0]   age_q [ENTRIES];
  logic [AGE_W-1:0]   age_d [ENTRIES];
  logic [IP_W-1:0]    ip_q  [ENTRIES];
  logic [MAC_W-1:0]   mac_q [ENTRIES];
  logic [CNT_W-1:0]   count_q;

  logic             learn_match, free_found;
  logic [IDX_W-1:0] match_idx, free_idx, old_idx, wr_idx;
  logic [AGE_W-1:0] old_age;

  function automatic logic [CNT_W-1:0] count_valid(input logic [ENTRIES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < ENTRIES; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Slot choice for a learn: refresh a matching entry, else the lowest free
  // slot, else the oldest entry (lowest index wins a tie). Decided on the
  // table as it stands before this edge's ageing.
  always_comb begin
    learn_match = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (ip_q[i] == learn_ip)) begin
        learn_match = 1'b1;
        match_idx   = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    old_idx = '0;
    old_age = age_q[0];
    for (int i = 1; i < ENTRIES; i++) begin
      if (age_q[i] > old_age) begin
        old_age = age_q[i];
        old_idx = IDX_W'(i);
      end
    end
    wr_idx = learn_match ? match_idx : (free_found ? free_idx : old_idx);
  end

  always_comb begin
    lookup_hit = 1'b0;
    lookup_mac = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (ip_q[i] == lookup_ip)) begin
        lookup_hit = 1'b1;
        lookup_mac = mac_q[i];
      end
    end
  end

  // Ageing and learn write; a learn landing on an entry in its expiry tick
  // leaves it valid with age 0.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i] = valid_q[i];
      age_d[i]   = age_q[i];
      if (flush) begin
        valid_d[i] = 1'b0;
        age_d[i]   = '0;
      end else begin
        if (tick && valid_q[i]) begin
          if (age_q[i] != AGE_W'(AGE_MAX)) age_d[i] = age_q[i] + AGE_W'(1);
          if (age_q[i] >= AGE_W'(AGE_MAX - 1)) valid_d[i] = 1'b0;
        end
        if (learn_valid && (wr_idx == IDX_W'(i))) begin
          valid_d[i] = 1'b1;
          age_d[i]   = '0;
        end
      end
    end
  end

  // ---- state registers: control reset, bindings unreset ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < ENTRIES; i++) age_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_valid(valid_d);
      for (int i = 0; i < ENTRIES; i++) age_q[i] <= age_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (learn_valid && !flush) begin
      ip_q[wr_idx]  <= learn_ip;
      mac_q[wr_idx] <= learn_mac;
    end
  end

  assign entry_count = count_q;

endmodule

// File: rtl/arp_cache.sv
// arp_cache: IP->MAC resolution cache with ARP request generation on miss.
//   clk, rstn                 : clock, asynchronous active-low reset
//   learn_valid/ip/mac        : binding received from ARP rx
//   lookup_req/ip, lookup_ready : lookup handshake (accepted while ready)
//   lookup_done/hit/mac       : one-cycle result; mac is 0 on a miss
//   req_en/req_ip, req_busy   : ARP request to tx, held off while busy
//   flush                     : drop all entries and abort an active lookup
//   entry_count               : number of valid entries
module arp_cache
  import arp_pkg::*;
#(
  parameter int ENTRIES       = 8,
  parameter int TICK_DIV      = 125000,
  parameter int AGE_MAX       = 60000,
  parameter int RETRY_TIMEOUT = 1000,
  parameter int RETRY_MAX     = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         learn_valid,
  input  logic [IP_W-1:0]              learn_ip,
  input  logic [MAC_W-1:0]             learn_mac,
  input  logic                         lookup_req,
  input  logic [IP_W-1:0]              lookup_ip,
  output logic                         lookup_ready,
  output logic                         lookup_done,
  output logic                         lookup_hit,
  output logic [MAC_W-1:0]             lookup_mac,
  output logic                         req_en,
  output logic [IP_W-1:0]              req_ip,
  input  logic                         req_busy,
  input  logic                         flush,
  output logic [$clog2(ENTRIES+1)-1:0] entry_count
);

  localparam int DIV_W = $clog2(TICK_DIV + 1);
  localparam int TMO_W = $clog2(RETRY_TIMEOUT + 1);
  localparam int RTY_W = $clog2(RETRY_MAX + 1);

  arp_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic [TMO_W-1:0] wait_q, wait_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             res_hit_q, res_hit_d;
  logic [MAC_W-1:0] res_mac_q, res_mac_d;
  logic [IP_W-1:0]  lk_ip_q, lk_ip_d;
  logic [IP_W-1:0]  req_ip_q, req_ip_d;
  logic             tbl_hit;
  logic [MAC_W-1:0] tbl_mac;

  arp_cache_table #(
    .ENTRIES (ENTRIES),
    .AGE_MAX (AGE_MAX)
  ) u_table (
    .clk         (clk),
    .rstn        (rstn),
    .tick        (tick),
    .flush       (flush),
    .learn_valid (learn_valid),
    .learn_ip    (learn_ip),
    .learn_mac   (learn_mac),
    .lookup_ip   (lookup_ip),
    .lookup_hit  (tbl_hit),
    .lookup_mac  (tbl_mac),
    .entry_count (entry_count)
  );

  // Free-running divider; its phase is never disturbed by the FSM, so a
  // timeout is accurate to one tick.
  assign tick = (div_q == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) div_q <= '0;
    else       div_q <= tick ? '0 : div_q + DIV_W'(1);
  end

  // ---- FSM state register ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      retry_q   <= '0;
      res_hit_q <= 1'b0;
      req_ip_q  <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retry_q   <= retry_d;
      res_hit_q <= res_hit_d;
      req_ip_q  <= req_ip_d;
    end
  end

  always_ff @(posedge clk) begin
    lk_ip_q   <= lk_ip_d;
    res_mac_q <= res_mac_d;
  end

  // ---- FSM next state ----
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    retry_d   = retry_q;
    res_hit_d = res_hit_q;
    res_mac_d = res_mac_q;
    lk_ip_d   = lk_ip_q;
    req_ip_d  = req_ip_q;
    unique case (state_q)
      ST_IDLE: begin
        if (lookup_req) begin
          lk_ip_d   = lookup_ip;
          res_hit_d = 1'b0;
          res_mac_d = '0;
          if (flush) begin
            state_d = ST_DONE;
          end else if (learn_valid && (learn_ip == lookup_ip)) begin
            // Same-cycle learn is newer than anything in the table.
            state_d   = ST_DONE;
            res_hit_d = 1'b1;
            res_mac_d = learn_mac;
          end else if (tbl_hit) begin
            state_d   = ST_DONE;
            res_hit_d = 1'b1;
            res_mac_d = tbl_mac;
          end else begin
            state_d  = ST_SEND;
            retry_d  = '0;
            req_ip_d = lookup_ip;
          end
        end
      end
      ST_SEND: begin
        if (flush) begin
          state_d   = ST_DONE;
          res_hit_d = 1'b0;
        end else if (!req_busy) begin
          state_d = ST_WAIT;
          retry_d = retry_q + RTY_W'(1);
          wait_d  = '0;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_d   = ST_DONE;
          res_hit_d = 1'b0;
        end else if (learn_valid && (learn_ip == lk_ip_q)) begin
          // A matching reply beats a timeout in the same cycle.
          state_d   = ST_DONE;
          res_hit_d = 1'b1;
          res_mac_d = learn_mac;
        end else if (tick) begin
          if (wait_q == TMO_W'(RETRY_TIMEOUT - 1)) begin
            if (retry_q < RTY_W'(RETRY_MAX)) state_d = ST_SEND;
            else                             state_d = ST_DONE;
          end else begin
            wait_d = wait_q + TMO_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- FSM outputs ----
  always_comb begin
    lookup_ready = (state_q == ST_IDLE);
    lookup_done  = (state_q == ST_DONE);
    lookup_hit   = lookup_done && res_hit_q;
    lookup_mac   = (lookup_done && res_hit_q) ? res_mac_q : '0;
    req_en       = (state_q == ST_SEND) && !req_busy && !flush;
    req_ip       = req_ip_q;
  end

endmodule
